// File: rtl/nmea_sentence_controller.sv
`timescale 1ns/1ps
// NMEA-0183 sentence framer: strips "$...*HH\r\n" framing, streams payload bytes
// to a buffer, verifies the XOR checksum and holds the sentence until acknowledged.
module nmea_sentence_controller #(
    parameter int max_sentence_length = 82,
    parameter int data_width          = 8,
    localparam int aw = $clog2(max_sentence_length),
    localparam int lw = $clog2(max_sentence_length + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  sentence_ack,
    output logic                  rx_enable,
    output logic                  wr_en,
    output logic [aw-1:0]         wr_addr,
    output logic [data_width-1:0] wr_data,
    output logic                  sentence_ready,
    output logic [lw-1:0]         sentence_length,
    output logic                  checksum_error,
    output logic                  framing_error,
    output logic                  overflow_error,
    output logic                  overrun_error
);

    typedef enum logic [2:0] {
        IDLE, PAYLOAD, CSUM_HI, CSUM_LO, WAIT_CR, WAIT_LF, HOLD
    } state_t;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    state_t                state, state_n;
    logic [lw-1:0]         count, count_n;
    logic [7:0]            checksum, checksum_n;
    logic [7:0]            rx_sum, rx_sum_n;
    logic [lw-1:0]         length_n;
    logic                  wr_en_n;
    logic [aw-1:0]         wr_addr_n;
    logic [data_width-1:0] wr_data_n;
    logic                  ready_n, csum_err_n, frame_err_n, ovf_err_n, ovr_err_n;
    logic [7:0]            rx_byte;
    logic [4:0]            hex;

    // Uppercase hex only; bit 4 flags a valid digit.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
        if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
        return '0;
    endfunction

    assign rx_byte   = rx_data[7:0];
    assign hex       = hex_decode(rx_byte);
    assign rx_enable = (state != HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            checksum        <= '0;
            rx_sum          <= '0;
            sentence_length <= '0;
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            sentence_ready  <= 1'b0;
            checksum_error  <= 1'b0;
            framing_error   <= 1'b0;
            overflow_error  <= 1'b0;
            overrun_error   <= 1'b0;
        end else begin
            state           <= state_n;
            count           <= count_n;
            checksum        <= checksum_n;
            rx_sum          <= rx_sum_n;
            sentence_length <= length_n;
            wr_en           <= wr_en_n;
            wr_addr         <= wr_addr_n;
            wr_data         <= wr_data_n;
            sentence_ready  <= ready_n;
            checksum_error  <= csum_err_n;
            framing_error   <= frame_err_n;
            overflow_error  <= ovf_err_n;
            overrun_error   <= ovr_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        checksum_n  = checksum;
        rx_sum_n    = rx_sum;
        length_n    = sentence_length;
        wr_en_n     = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        ready_n     = 1'b0;
        csum_err_n  = 1'b0;
        frame_err_n = 1'b0;
        ovf_err_n   = 1'b0;
        ovr_err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid && rx_byte == CH_DOLLAR) begin
                    state_n    = PAYLOAD;
                    count_n    = '0;
                    checksum_n = '0;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    if (rx_byte == CH_DOLLAR) begin
                        count_n    = '0;
                        checksum_n = '0;
                    end else if (rx_byte == CH_STAR) begin
                        state_n = CSUM_HI;
                    end else if (rx_byte == CH_CR || rx_byte == CH_LF) begin
                        frame_err_n = 1'b1;
                        state_n     = IDLE;
                    end else if (count == lw'(max_sentence_length)) begin
                        ovf_err_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        wr_en_n    = 1'b1;
                        wr_addr_n  = count[aw-1:0];
                        wr_data_n  = rx_data;
                        count_n    = count + lw'(1);
                        checksum_n = checksum ^ rx_byte;
                    end
                end
            end
            CSUM_HI, CSUM_LO: begin
                if (rx_valid) begin
                    if (!hex[4]) begin
                        frame_err_n = 1'b1;
                        state_n     = IDLE;
                    end else if (state == CSUM_HI) begin
                        rx_sum_n[7:4] = hex[3:0];
                        state_n       = CSUM_LO;
                    end else begin
                        rx_sum_n[3:0] = hex[3:0];
                        state_n       = WAIT_CR;
                    end
                end
            end
            WAIT_CR: begin
                if (rx_valid) begin
                    if (rx_byte == CH_CR) begin
                        state_n = WAIT_LF;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = IDLE;
                    end
                end
            end
            WAIT_LF: begin
                if (rx_valid) begin
                    if (rx_byte != CH_LF) begin
                        frame_err_n = 1'b1;
                        state_n     = IDLE;
                    end else if (rx_sum == checksum) begin
                        ready_n  = 1'b1;
                        length_n = count;
                        state_n  = HOLD;
                    end else begin
                        csum_err_n = 1'b1;
                        state_n    = IDLE;
                    end
                end
            end
            HOLD: begin
                // Bytes arriving while the buffer is owned by the consumer are lost.
                if (rx_valid) ovr_err_n = 1'b1;
                if (sentence_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nmea_sentence_controller.sv
`timescale 1ns/1ps
// Directed bench for nmea_sentence_controller: default-size instance plus a
// 4-byte instance sharing the same stimulus for the overflow boundary.
module tb_nmea_sentence_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       sentence_ack = 1'b0;

    logic       en, we, rdy, ce, fe, oe, ore;
    logic [6:0] wa, len;
    logic [7:0] wd;
    logic       en4, we4, rdy4, ce4, fe4, oe4, ore4;
    logic [1:0] wa4;
    logic [2:0] len4;
    logic [7:0] wd4;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulses4 = 0;
    int p0;

    nmea_sentence_controller dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .sentence_ack(sentence_ack), .rx_enable(en), .wr_en(we), .wr_addr(wa),
        .wr_data(wd), .sentence_ready(rdy), .sentence_length(len),
        .checksum_error(ce), .framing_error(fe), .overflow_error(oe),
        .overrun_error(ore)
    );

    nmea_sentence_controller #(.max_sentence_length(4), .data_width(8)) dut4 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .sentence_ack(sentence_ack), .rx_enable(en4), .wr_en(we4), .wr_addr(wa4),
        .wr_data(wd4), .sentence_ready(rdy4), .sentence_length(len4),
        .checksum_error(ce4), .framing_error(fe4), .overflow_error(oe4),
        .overrun_error(ore4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdy | ce | fe | oe | ore) pulses++;
        if (rdy4 | ce4 | fe4 | oe4 | ore4) pulses4++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte is presented for one cycle; on return the registered response is visible.
    task automatic send(input logic [7:0] b, input logic ack);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1; sentence_ack = ack;
        @(posedge clk); #1;
        rx_valid = 1'b0; sentence_ack = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
    endtask

    task automatic ack_only();
        @(posedge clk); #1; sentence_ack = 1'b1;
        @(posedge clk); #1; sentence_ack = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_en", en, 1);
        chk("rst_wr", {we, wa, wd}, 0);
        chk("rst_len", len, 0);
        chk("rst_pulses", {rdy, ce, fe, oe, ore}, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Good sentence "$AB*03\r\n"
        send("$", 0);
        send("A", 0);
        chk("wr0", {we, wa, wd}, {1'b1, 7'd0, 8'h41});
        send("B", 0);
        chk("wr1", {we, wa, wd}, {1'b1, 7'd1, 8'h42});
        send_str("*03\r");
        chk("no_rdy_before_lf", rdy, 0);
        send(8'h0A, 0);
        chk("rdy", rdy, 1);
        chk("len", len, 2);
        chk("en_hold", en, 0);
        chk("rdy4", {rdy4, len4}, {1'b1, 3'd2});
        @(posedge clk); #1;
        chk("rdy_one_cycle", {rdy, en}, 2'b00);

        // Overrun in HOLD, then ack with simultaneous byte
        send(8'h55, 0);
        chk("ovr", {ore, we, en}, 3'b100);
        send(8'h55, 1);
        chk("ovr_ack", {ore, en}, 2'b11);
        chk("len_after_ack", len, 2);

        // Checksum mismatch
        send_str("$AB*04\r");
        send(8'h0A, 0);
        chk("csum_err", {ce, rdy, en}, 3'b101);

        // Overflow boundary on the 4-byte instance
        send_str("$ABC");
        send("D", 0);
        chk("wr4_last", {we4, wa4, wd4}, {1'b1, 2'd3, 8'h44});
        send("E", 0);
        chk("ovf4", {oe4, we4}, 2'b10);
        chk("no_ovf82", {oe, we, wa}, {1'b0, 1'b1, 7'd4});
        send_str("$AB*03\r");
        send(8'h0A, 0);
        chk("rdy4_after_ovf", {rdy4, len4}, {1'b1, 3'd2});
        chk("rdy_after_ovf", {rdy, len}, {1'b1, 7'd2});
        ack_only();
        chk("ack_release", {en, en4}, 2'b11);

        // Resync on second '$'
        send_str("$A$");
        send("A", 0);
        chk("resync_wr", {we, wa, wd}, {1'b1, 7'd0, 8'h41});
        send_str("B*03\r");
        send(8'h0A, 0);
        chk("resync_rdy", {rdy, len}, {1'b1, 7'd2});
        ack_only();

        // Framing errors: lowercase hex and CR inside payload
        send_str("$AB*0");
        send("g", 0);
        chk("fe_hex", {fe, we}, 2'b10);
        send_str("$A");
        send(8'h0D, 0);
        chk("fe_cr", {fe, we}, 2'b10);

        // Empty payload
        send_str("$*00\r");
        send(8'h0A, 0);
        chk("empty_rdy", {rdy, len}, {1'b1, 7'd0});
        ack_only();

        // Reset mid-sentence
        send_str("$AB");
        @(posedge clk); #1; rst = 1'b1;
        #1;
        chk("mid_rst_wr", {we, wa, wd}, 0);
        chk("mid_rst_misc", {en, len, rdy, ce, fe, oe, ore}, {1'b1, 7'd0, 5'd0});
        #10; rst = 1'b0;
        p0 = pulses;
        send_str("*03\r\n");
        repeat (2) @(posedge clk);
        #1;
        chk("no_pulse_after_rst", pulses - p0, 0);
        chk("en_after_rst", en, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nmea_sentence_controller.md
NMEA_SENTENCE_CONTROLLER -- requirements
Module: nmea_sentence_controller

Interface
REQ-001 Parameter max_sentence_length, default 82, max payload bytes stored per sentence (>=2).
REQ-002 Parameter data_width, default 8, width of received byte.
REQ-003 Derived: aw = $clog2(max_sentence_length); lw = $clog2(max_sentence_length+1).
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, all logic on posedge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 rx_data  in  data_width  byte from UART receiver, valid only with rx_valid.
REQ-008 rx_valid  in  1  one-cycle strobe per received byte.
REQ-009 sentence_ack  in  1  consumer has read the buffer; releases HOLD.
REQ-010 rx_enable  out  1  receiver may deliver bytes; low only in HOLD.
REQ-011 wr_en  out  1  payload buffer write strobe.
REQ-012 wr_addr  out  aw  payload buffer address.
REQ-013 wr_data  out  data_width  payload byte to store.
REQ-014 sentence_ready  out  1  one-cycle pulse: valid sentence complete.
REQ-015 sentence_length  out  lw  payload byte count; stable from sentence_ready until ack.
REQ-016 checksum_error, framing_error, overflow_error, overrun_error  out  1 each  one-cycle error pulses.

Function
REQ-017 States: IDLE, PAYLOAD, CSUM_HI, CSUM_LO, WAIT_CR, WAIT_LF, HOLD; transitions only on rx_valid except HOLD exit.
REQ-018 Payload = bytes strictly between '$' (0x24) and '*' (0x2A); running checksum = XOR of payload bytes, 8 bits.
REQ-019 IDLE: '$' -> PAYLOAD, count=0, checksum=0; every other byte ignored, no error.
REQ-020 PAYLOAD, ordinary byte, count<max: wr_en=1, wr_addr=count, wr_data=byte, same cycle-registered (outputs one cycle after rx_valid); count++, checksum^=byte.
REQ-021 PAYLOAD, ordinary byte, count==max: overflow_error pulse, no write, -> IDLE.
REQ-022 PAYLOAD, '$': resync -- count=0, checksum=0, stay PAYLOAD, no error pulse.
REQ-023 PAYLOAD, 0x0D or 0x0A: framing_error, -> IDLE.
REQ-024 PAYLOAD, '*': -> CSUM_HI (empty payload allowed, checksum 0x00).
REQ-025 CSUM_HI/CSUM_LO accept uppercase hex only ('0'-'9','A'-'F'); nibble stored high then low; any other byte: framing_error, -> IDLE.
REQ-026 WAIT_CR requires 0x0D -> WAIT_LF; WAIT_LF requires 0x0A; otherwise framing_error, -> IDLE.
REQ-027 On LF: checksum match -> sentence_ready pulse, sentence_length=count, -> HOLD; mismatch -> checksum_error, -> IDLE.
REQ-028 Latency: sentence_ready/error pulses assert exactly one clk after the rx_valid cycle of the deciding byte.
REQ-029 HOLD: rx_enable=0; any rx_valid byte dropped with overrun_error pulse; no buffer writes.
REQ-030 HOLD + sentence_ack -> IDLE next cycle; simultaneous rx_valid that cycle: byte dropped, overrun_error, still -> IDLE.
REQ-031 sentence_ack outside HOLD ignored.
REQ-032 At most one error/ready pulse per input byte; wr_en never asserted in same cycle as any error pulse.

Reset
REQ-033 rst asserted: state=IDLE, count=0, checksum=0, sentence_length=0, rx_enable=1, wr_en/wr_addr/wr_data=0, all pulses 0.
REQ-034 rst mid-sentence discards partial sentence; no pulse produced by or after reset until new '$'.

Verification
REQ-035 "$AB*03\r\n" -> writes 0x41@0, 0x42@1; sentence_ready one cycle after LF; sentence_length=2; rx_enable=0.
REQ-036 "$AB*04\r\n" -> checksum_error after LF, no ready, state IDLE, rx_enable=1.
REQ-037 max_sentence_length=4, "$ABCDE" -> 4 writes (addr 0-3), overflow_error on 'E'; following "$AB*03\r\n" accepted.
REQ-038 "$A$AB*03\r\n" -> resync, sentence_ready, length 2, addr 0 rewritten with 0x41; "$AB*0g" -> framing_error on 'g'.
REQ-039 In HOLD send 0x55 -> overrun_error, no write; ack with simultaneous rx_valid -> overrun_error, IDLE next cycle.
REQ-040 rst pulse after "$AB" -> all outputs reset values; then "*03\r\n" produces no pulse.
